// File: rtl/load_store_unit.sv
// Load/store stage: turns core load/store requests into one word-wide memory bus access with byte enables.
// Accept-to-done is 2 cycles when mem_ready arrives on the first bus cycle; rejected requests complete 1 cycle after accept.
// busy stalls the core from the request cycle through done; mem_req is held until mem_ready or timeout.
module load_store_unit #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        illegal, misaligned;
    logic [3:0]  be_req;
    logic [31:0] wdata_req;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Request decode, evaluated on the raw inputs in the accept cycle.
    always_comb begin
        illegal    = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111)
                   || (funct3_i[2] && req_write_i);
        misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0])
                   || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        case (funct3_i[1:0])
            2'b00:   be_req = 4'b0001 << addr_i[1:0];
            2'b01:   be_req = 4'b0011 << addr_i[1:0];
            default: be_req = 4'b1111;
        endcase
        case (funct3_i[1:0])
            2'b00:   wdata_req = {4{wdata_i[7:0]}};
            2'b01:   wdata_req = {2{wdata_i[15:0]}};
            default: wdata_req = wdata_i;
        endcase
    end

    always_comb begin
        byte_sel = mem_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = mem_rdata_i;
        endcase
        if (we_q) begin
            load_val = 32'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_write_i;
                    f3_d    = funct3_i;
                    lane_d  = addr_i[1:0];
                    addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                    be_d    = be_req;
                    wdata_d = wdata_req;
                    if (illegal || misaligned) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // A ready arriving on the final allowed cycle still counts as success.
                if (mem_ready_i) begin
                    rdata_d = load_val;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus strobes come straight from the state register so reset drops them without waiting for a clock.
    assign busy_o      = (state_q == S_IDLE) ? req_valid_i : 1'b1;
    assign done_o      = (state_q == S_DONE);
    assign mem_req_o   = (state_q == S_BUS);
    assign mem_we_o    = (state_q == S_BUS) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with an arithmetic reference model.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;
    localparam int ADDR_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid, req_write, mem_ready;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata, mem_rdata;
    logic              busy, done, err, mem_req, mem_we;
    logic [31:0]       rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_write_i(req_write), .funct3_i(funct3),
        .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .rdata_o(rdata), .err_o(err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference: access size, legality, lane placement and extension from plain arithmetic.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         output logic bad, output logic [3:0] be,
                         output logic [31:0] mw, output logic [31:0] rv);
        int unsigned size, off, mask, v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = a % 4;
        bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4)
            || ((a % size) != 0);
        be   = 4'(((1 << size) - 1) << off);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((1 << (8 * size)) - 1);
        if (size == 1)      mw = (wd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) mw = (wd & 32'hFFFF) * 32'h0001_0001;
        else                mw = wd;
        v = (rd >> (8 * off)) & mask;
        if (f3 < 3'd4 && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
            v = v | ~mask;
        rv = wr ? 32'd0 : v;
    endtask

    // One complete access; delay = BUS cycles before mem_ready (>= TIMEOUT means never).
    task automatic do_txn(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int delay);
        logic bad, exp_err;
        logic [3:0] ebe;
        logic [31:0] emw, erv;
        int nbus;
        model(wr, f3, a, wd, rd, bad, ebe, emw, erv);
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check({tag, ":busy_req"}, busy, 1);
        check({tag, ":done_idle"}, done, 0);
        step();
        req_valid = 1'b0; mem_ready = 1'b0;
        if (bad) begin
            check({tag, ":no_req"}, mem_req, 0);
            exp_err = 1'b1;
            erv     = 32'd0;
        end else begin
            nbus    = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
            exp_err = (delay >= TIMEOUT);
            if (exp_err) erv = 32'd0;
            for (int c = 0; c < nbus; c++) begin
                check({tag, ":mem_req"}, mem_req, 1);
                check({tag, ":done_bus"}, done, 0);
                if (c == 0) begin
                    check({tag, ":mem_addr"}, mem_addr, {a[31:2], 2'b00});
                    check({tag, ":mem_be"}, mem_be, ebe);
                    check({tag, ":mem_we"}, mem_we, wr);
                    if (wr) check({tag, ":mem_wdata"}, mem_wdata, emw);
                end
                mem_ready = (c == delay);
                mem_rdata = (c == delay) ? rd : $urandom;
                step();
                mem_ready = 1'b0;
            end
        end
        check({tag, ":done"}, done, 1);
        check({tag, ":busy_done"}, busy, 1);
        check({tag, ":err"}, err, exp_err);
        check({tag, ":rdata"}, rdata, erv);
        check({tag, ":req_after"}, mem_req, 0);
        step();
        check({tag, ":done_clr"}, done, 0);
        check({tag, ":busy_clr"}, busy, 0);
        check({tag, ":rdata_hold"}, rdata, erv);
    endtask

    initial begin
        logic [2:0] rf3;
        logic       rwr;
        logic [31:0] ra;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'd0;
        addr = '0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        #12;
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:err", err, 0);
        check("rst:mem_req", mem_req, 0);
        check("rst:mem_we", mem_we, 0);
        check("rst:rdata", rdata, 0);
        check("rst:mem_addr", mem_addr, 0);
        check("rst:mem_be", mem_be, 0);
        check("rst:mem_wdata", mem_wdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        do_txn("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        do_txn("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
        check("lb_103:val", rdata, 32'hFFFF_FF80);
        do_txn("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0);
        check("lbu_103:val", rdata, 32'h0000_0080);
        do_txn("sh_202",  1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h1111_2222, 1);
        do_txn("lw_101",  1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        do_txn("sw_tmo",  1'b1, 3'b010, 32'h300, 32'h1234_5678, 32'h0, 1000);
        do_txn("sw_last", 1'b1, 3'b010, 32'h300, 32'h1234_5678, 32'h0, TIMEOUT - 1);
        do_txn("sbu_ill", 1'b1, 3'b100, 32'h300, 32'h0, 32'h0, 0);

        // Reset in the middle of the third bus cycle.
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("rst_mid:req_before", mem_req, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid:mem_req", mem_req, 0);
        check("rst_mid:busy", busy, 0);
        check("rst_mid:done", done, 0);
        step();
        check("rst_mid:no_done", done, 0);
        reset_n = 1'b1;
        step();
        do_txn("lw_after_rst", 1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 2);

        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            rwr = 1'($urandom_range(0, 1));
            ra  = $urandom;
            do_txn($sformatf("rnd%0d", i), rwr, rf3, ra, $urandom, $urandom,
                   ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
